endec_axis_interface: RTL and testbench
=======================================

Name: endec_axis_interface

Overview:
- AXI4-Stream wrapper around a configurable convolutional encoder and a hard-decision Viterbi decoder (K ≤ 9, rate 1/2 or 1/3).
- Accepts one config beat, then 8 data beats carrying a 384-bit decoder frame and a 128-bit encoder frame.
- Encodes and decodes both frames, then returns 8 result beats.
- Sits between the host DMA stream and the channel-coding datapath.

Parameters:
- MAX_CONSTRAINT_LENGTH, 9, shift-register length (from shared package)
- MAX_CODE_RATE, 3, maximum number of generator polynomials
- DATA_W, 64, AXIS beat width

Ports:
- sys_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  64  input beats
- s_axis_tlast  in  1  packet end; ignored, beats are counted
- s_axis_tready  out  1  ready to accept input
- s_axis_tvalid  in  1  input beat valid
- m_axis_tdata  out  64  result beats
- m_axis_tlast  out  1  high on result beat 7
- m_axis_tready  in  1  downstream ready
- m_axis_tvalid  out  1  result beat valid

Behaviour:
- Reset (async, rst_n=0):
  - State RX_CFG.
  - All outputs 0.
  - Config and frame registers cleared.
  - Reset mid-operation aborts the transaction; no partial output.
- Handshake: a beat transfers on tvalid&tready at a sys_clk edge.
- Input order, MSB first:
  - Config beat: bits[26:0] hold three 9-bit generator polynomials, g0=[8:0], g1=[17:9], g2=[26:18]. Bit 27 is code_rate: 0 = rate 1/2, 1 = rate 1/3. Other bits are ignored.
  - Data beats 0–5 carry decoder frame bits [383:0], beat 0 = [383:320].
  - Data beats 6–7 carry encoder frame bits [127:0].
- FSM:
  - RX_CFG: s_axis_tready=1. One beat latches config, then go to RX_DATA.
  - RX_DATA: s_axis_tready=1. After 8 beats go to ENCODE.
  - ENCODE: 1 input bit per cycle, 128 cycles, then go to DECODE.
  - DECODE: start viterbi_core and wait for its done, then go to TX.
  - TX: m_axis_tvalid=1. After the beat-7 handshake go to RX_CFG.
  - s_axis_tready=0 outside RX_CFG/RX_DATA.
- Encoder:
  - State s[8:0] starts at 0. Input is frame bit 127 first.
  - Each cycle: s = {s[7:0], in}, so s[0] is the current bit and s[k] is the input k cycles earlier.
  - c_j = XOR(s & g_j).
  - Rate 1/3 output: input bit i (counted from the MSB) produces bits 383-3i, 382-3i, 381-3i = c0, c1, c2.
  - Rate 1/2 output: uses bits [255:0] the same way with pairs; bits [383:256] are 0.
  - No tail bits are appended.
- Decoder:
  - Rate 1/3 reads all 384 bits; rate 1/2 reads bits [255:0].
  - Same symbol ordering as the encoder.
  - 256 states, start state 0, Hamming branch metrics.
  - Full-frame traceback from the minimum-metric end state; ties go to the lowest state index.
  - Outputs 128 bits, first decoded bit in bit 127.
- Output order:
  - Beats 0–1: decoder result [127:0].
  - Beats 2–7: encoder result [383:0], beat 2 = [383:320].
  - m_axis_tlast=1 only on beat 7.
  - m_axis_tdata and m_axis_tlast stay stable while tvalid&!tready.
  - First result beat appears 1 cycle after decode completes.
- Input is not accepted while TX is active; a new config beat is accepted only after beat 7 transfers.

Optional Feature:
- Macro ENDEC_DECODER_EN.
- Defined: viterbi_core is instantiated and DECODE runs as above.
- Undefined: no decoder logic; DECODE is skipped and decoder-result beats 0–1 are all zeros; the rest is unchanged.

Decomposition:
- Package endec_pkg holds:
  - MAX_CONSTRAINT_LENGTH, MAX_CODE_RATE
  - CODE_RATE_2=1'b0, CODE_RATE_3=1'b1
  - FSM state enum
  - config field offsets
- One sub-module, viterbi_core:
  - Inputs: start, code_rate, gen_poly_flat, 384-bit frame.
  - Outputs: done pulse, 128-bit data.
- The encoder and AXIS sequencing stay in endec_axis_interface.

Test Plan:
- Rate 1/2, g0=9'h007, g1=9'h005, encoder frame 128'h8000…0 → encoder result bits[255:250]=6'b111011, all other bits 0; decoder fed the same stream returns 128'h8000…0.
- Rate 1/3, polys 9'b111101101, 9'b110011011, 9'b100100111, random 128-bit frame → encode it, send the result as the next decoder frame; decoded output equals the frame.
- Single bit flipped at bit 200 of a valid rate-1/3 codeword → decoder output equals the original frame.
- m_axis_tready held low for 5 cycles during beat 3 → tdata/tlast stable; 8 beats total, tlast only on the last.
- rst_n pulsed low after data beat 4 → all outputs 0 immediately; a fresh 9-beat transaction completes correctly.
- s_axis_tvalid toggled every other cycle → correct result; s_axis_tready low from ENCODE until the end of TX.

Source files
------------

// File: rtl/endec_pkg.sv
// Shared constants, config field offsets and state encodings for the channel-coding
// wrapper and its Viterbi decoder.
package endec_pkg;

    localparam int MAX_CONSTRAINT_LENGTH = 9;
    localparam int MAX_CODE_RATE         = 3;

    localparam logic CODE_RATE_2 = 1'b0;
    localparam logic CODE_RATE_3 = 1'b1;

    localparam int ENC_FRAME_W = 128;
    localparam int DEC_FRAME_W = ENC_FRAME_W * MAX_CODE_RATE;
    localparam int GEN_POLY_W  = MAX_CONSTRAINT_LENGTH * MAX_CODE_RATE;
    localparam int NUM_STATES  = 1 << (MAX_CONSTRAINT_LENGTH - 1);

    localparam int CFG_G0_LSB   = 0;
    localparam int CFG_G1_LSB   = 9;
    localparam int CFG_G2_LSB   = 18;
    localparam int CFG_RATE_BIT = 27;

    typedef enum logic [2:0] {
        RX_CFG  = 3'd0,
        RX_DATA = 3'd1,
        ENCODE  = 3'd2,
        DECODE  = 3'd3,
        TX      = 3'd4
    } endec_state_e;

    typedef enum logic [1:0] {
        VIT_IDLE = 2'd0,
        VIT_ACS  = 2'd1,
        VIT_FIND = 2'd2,
        VIT_TB   = 2'd3
    } vit_phase_e;

    function automatic logic poly_parity(input logic [MAX_CONSTRAINT_LENGTH-1:0] s,
                                         input logic [MAX_CONSTRAINT_LENGTH-1:0] g);
        return ^(s & g);
    endfunction

endpackage

// File: rtl/endec_axis_interface_viterbi_core.sv
// Hard-decision 256-state Viterbi decoder: one trellis step per cycle, then full traceback.
// Only compiled when ENDEC_DECODER_EN is defined.
`ifdef ENDEC_DECODER_EN
module viterbi_core
    import endec_pkg::*;
(
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   code_rate_i,
    input  logic [GEN_POLY_W-1:0]  gen_poly_flat_i,
    input  logic [DEC_FRAME_W-1:0] frame_i,
    output logic                   done_o,
    output logic [ENC_FRAME_W-1:0] data_o
);
    localparam int SW = MAX_CONSTRAINT_LENGTH - 1;
    localparam int MW = 10;
    // Unreached states start high enough to lose, low enough never to overflow.
    localparam logic [MW-1:0] PM_INIT = 10'd512;

    vit_phase_e             phase_q;
    logic [6:0]             cnt_q;
    logic [DEC_FRAME_W-1:0] sym_q;
    logic [MW-1:0]          pm_q [NUM_STATES];
    logic [MW-1:0]          pm_d [NUM_STATES];
    logic [NUM_STATES-1:0]  dec_d;
    logic [NUM_STATES-1:0]  surv_q [ENC_FRAME_W];
    logic [SW-1:0]          tb_q;
    logic [SW-1:0]          best_state;
    logic [ENC_FRAME_W-1:0] data_q;
    logic                   done_q;
    logic [2:0]             rx_sym;
    logic [MW-1:0]          cand0;
    logic [MW-1:0]          cand1;

    function automatic logic [1:0] branch_metric(input logic [SW:0] r9,
                                                 input logic [GEN_POLY_W-1:0] g,
                                                 input logic rate3,
                                                 input logic [2:0] rx);
        logic [2:0] diff;
        diff = {poly_parity(r9, g[CFG_G0_LSB +: SW+1]),
                poly_parity(r9, g[CFG_G1_LSB +: SW+1]),
                poly_parity(r9, g[CFG_G2_LSB +: SW+1])} ^ rx;
        if (!rate3) diff[0] = 1'b0;
        return 2'(diff[2]) + 2'(diff[1]) + 2'(diff[0]);
    endfunction

    assign rx_sym = (code_rate_i == CODE_RATE_2) ? {sym_q[DEC_FRAME_W-1 -: 2], 1'b0}
                                                 : sym_q[DEC_FRAME_W-1 -: 3];

    // State n = last 8 inputs, n[0] newest; predecessor x gives full register {x, n}.
    always_comb begin
        pm_d  = pm_q;
        dec_d = '0;
        cand0 = '0;
        cand1 = '0;
        for (int n = 0; n < NUM_STATES; n++) begin
            cand0 = pm_q[{1'b0, n[SW-1:1]}]
                  + MW'(branch_metric({1'b0, n[SW-1:0]}, gen_poly_flat_i, code_rate_i, rx_sym));
            cand1 = pm_q[{1'b1, n[SW-1:1]}]
                  + MW'(branch_metric({1'b1, n[SW-1:0]}, gen_poly_flat_i, code_rate_i, rx_sym));
            dec_d[n] = (cand1 < cand0);
            pm_d[n]  = (cand1 < cand0) ? cand1 : cand0;
        end
    end

    always_comb begin
        best_state = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_q[i] < pm_q[best_state]) best_state = SW'(i);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (phase_q == VIT_ACS) surv_q[~cnt_q] <= dec_d;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= VIT_IDLE;
            cnt_q   <= '0;
            sym_q   <= '0;
            tb_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            for (int s = 0; s < NUM_STATES; s++) pm_q[s] <= '0;
        end else begin
            done_q <= 1'b0;
            case (phase_q)
                VIT_IDLE: begin
                    if (start_i) begin
                        for (int s = 0; s < NUM_STATES; s++) pm_q[s] <= (s == 0) ? '0 : PM_INIT;
                        sym_q   <= (code_rate_i == CODE_RATE_2)
                                   ? {frame_i[2*ENC_FRAME_W-1:0], {ENC_FRAME_W{1'b0}}} : frame_i;
                        cnt_q   <= 7'd127;
                        phase_q <= VIT_ACS;
                    end
                end
                VIT_ACS: begin
                    pm_q  <= pm_d;
                    sym_q <= (code_rate_i == CODE_RATE_2) ? sym_q << 2 : sym_q << 3;
                    if (cnt_q == 7'd0) phase_q <= VIT_FIND;
                    else               cnt_q   <= cnt_q - 7'd1;
                end
                VIT_FIND: begin
                    tb_q    <= best_state;
                    cnt_q   <= 7'd127;
                    phase_q <= VIT_TB;
                end
                VIT_TB: begin
                    data_q <= {tb_q[0], data_q[ENC_FRAME_W-1:1]};
                    tb_q   <= {surv_q[cnt_q][tb_q], tb_q[SW-1:1]};
                    if (cnt_q == 7'd0) begin
                        done_q  <= 1'b1;
                        phase_q <= VIT_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 7'd1;
                    end
                end
                default: phase_q <= VIT_IDLE;
            endcase
        end
    end

    assign done_o = done_q;
    assign data_o = data_q;

endmodule
`endif

// File: rtl/endec_axis_interface.sv
// AXI4-Stream wrapper: config beat + 8 data beats in, convolutional encode and optional
// Viterbi decode (ENDEC_DECODER_EN), 8 result beats out.
//
// state   | meaning
// RX_CFG  | waiting for the config beat (polynomials, code rate)
// RX_DATA | collecting 6 decoder-frame beats then 2 encoder-frame beats
// ENCODE  | shifting one encoder input bit per cycle, 128 cycles
// DECODE  | viterbi_core running, wait for done
// TX      | presenting result beats 0..7
module endec_axis_interface #(
    parameter int MAX_CONSTRAINT_LENGTH = endec_pkg::MAX_CONSTRAINT_LENGTH,
    parameter int MAX_CODE_RATE         = endec_pkg::MAX_CODE_RATE,
    parameter int DATA_W                = 64
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    input  logic              s_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              m_axis_tvalid
);
    import endec_pkg::*;

    localparam int POLY_W = MAX_CONSTRAINT_LENGTH;
    localparam int ENC_W  = ENC_FRAME_W;
    localparam int DEC_W  = ENC_W * MAX_CODE_RATE;

    endec_state_e              state_q, state_d;
    logic [6:0]                cnt_q, cnt_d;
    logic                      s_ready_q, s_ready_d;
    logic [POLY_W*MAX_CODE_RATE-1:0] poly_q;
    logic                      rate_q;
    logic [DEC_W-1:0]          dec_frame_q;
    logic [ENC_W-1:0]          enc_frame_q;
    logic [DEC_W-1:0]          enc_res_q;
    logic [POLY_W-2:0]         enc_s_q;
    logic [POLY_W-1:0]         enc_s_next;
    logic [2:0]                enc_c;
    logic [ENC_W-1:0]          dec_res;
    logic                      dec_done;
    logic                      dec_start;
    logic                      s_hs;
    logic [ENC_W+DEC_W-1:0]    tx_vec;
    logic                      unused_tlast;

    assign unused_tlast = s_axis_tlast;
    assign s_axis_tready = s_ready_q;
    assign s_hs          = s_axis_tvalid & s_ready_q;
    assign tx_vec        = {dec_res, enc_res_q};

    assign enc_s_next = {enc_s_q, enc_frame_q[ENC_W-1]};
    assign enc_c      = {poly_parity(enc_s_next, poly_q[CFG_G0_LSB +: POLY_W]),
                         poly_parity(enc_s_next, poly_q[CFG_G1_LSB +: POLY_W]),
                         poly_parity(enc_s_next, poly_q[CFG_G2_LSB +: POLY_W])};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dec_start     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        case (state_q)
            RX_CFG: begin
                if (s_hs) begin
                    state_d = RX_DATA;
                    cnt_d   = 7'd7;
                end
            end
            RX_DATA: begin
                if (s_hs) begin
                    if (cnt_q == 7'd0) begin
                        state_d = ENCODE;
                        cnt_d   = 7'd127;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
            end
            ENCODE: begin
                if (cnt_q == 7'd0) begin
`ifdef ENDEC_DECODER_EN
                    state_d   = DECODE;
                    dec_start = 1'b1;
`else
                    state_d   = TX;
                    cnt_d     = 7'd7;
`endif
                end else begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            DECODE: begin
                if (dec_done) begin
                    state_d = TX;
                    cnt_d   = 7'd7;
                end
            end
            TX: begin
                // cnt_q counts down 7..0, so it is also the 64-bit slot index from the LSB.
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (cnt_q == 7'd0);
                m_axis_tdata  = tx_vec[{cnt_q[2:0], 6'b0} +: DATA_W];
                if (m_axis_tready) begin
                    if (cnt_q == 7'd0) state_d = RX_CFG;
                    else               cnt_d   = cnt_q - 7'd1;
                end
            end
            default: state_d = RX_CFG;
        endcase
        s_ready_d = (state_d == RX_CFG) || (state_d == RX_DATA);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_CFG;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            poly_q      <= '0;
            rate_q      <= CODE_RATE_2;
            dec_frame_q <= '0;
            enc_frame_q <= '0;
            enc_res_q   <= '0;
            enc_s_q     <= '0;
        end else begin
            if (state_q == RX_CFG && s_hs) begin
                poly_q    <= s_axis_tdata[POLY_W*MAX_CODE_RATE-1:0];
                rate_q    <= s_axis_tdata[CFG_RATE_BIT];
                enc_res_q <= '0;
                enc_s_q   <= '0;
            end
            if (state_q == RX_DATA && s_hs) begin
                if (cnt_q >= 7'd2) dec_frame_q <= {dec_frame_q[DEC_W-DATA_W-1:0], s_axis_tdata};
                else               enc_frame_q <= {enc_frame_q[ENC_W-DATA_W-1:0], s_axis_tdata};
            end
            if (state_q == ENCODE) begin
                enc_s_q     <= enc_s_next[POLY_W-2:0];
                enc_frame_q <= enc_frame_q << 1;
                // Rate 1/2 shifts pairs, so after 128 steps [383:256] still hold the cleared zeros.
                enc_res_q   <= (rate_q == CODE_RATE_3) ? {enc_res_q[DEC_W-4:0], enc_c}
                                                       : {enc_res_q[DEC_W-3:0], enc_c[2:1]};
            end
        end
    end

`ifdef ENDEC_DECODER_EN
    viterbi_core u_viterbi_core (
        .sys_clk         (sys_clk),
        .rst_n           (rst_n),
        .start_i         (dec_start),
        .code_rate_i     (rate_q),
        .gen_poly_flat_i (poly_q),
        .frame_i         (dec_frame_q),
        .done_o          (dec_done),
        .data_o          (dec_res)
    );
`else
    logic unused_dec;
    assign unused_dec = dec_start ^ (^dec_frame_q);
    assign dec_res    = '0;
    assign dec_done   = 1'b0;
`endif

endmodule

// File: tb/tb_endec_axis_interface.sv
// Randomized bench for endec_axis_interface against a bit-level model of the encoder rules
// and the known-frame property of the decoder.
module tb_endec_axis_interface;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        s_axis_tvalid;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        m_axis_tvalid;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    endec_axis_interface dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] enc_model(input logic [127:0] f, input logic [63:0] cfg);
        logic [8:0]   s  = '0;
        logic [8:0]   g0 = cfg[8:0];
        logic [8:0]   g1 = cfg[17:9];
        logic [8:0]   g2 = cfg[26:18];
        logic [383:0] r  = '0;
        logic         c0, c1, c2;
        for (int i = 0; i < 128; i++) begin
            s  = {s[7:0], f[127-i]};
            c0 = ^(s & g0);
            c1 = ^(s & g1);
            c2 = ^(s & g2);
            if (cfg[27]) begin
                r[383-3*i] = c0;
                r[382-3*i] = c1;
                r[381-3*i] = c2;
            end else begin
                r[255-2*i] = c0;
                r[254-2*i] = c1;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_beat(input logic [63:0] d, input bit gap);
        int n = 0;
        if (gap) begin
            @(negedge sys_clk);
            s_axis_tvalid = 1'b0;
        end
        @(negedge sys_clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        while (!s_axis_tready && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        if (!s_axis_tready) check("s_ready_timeout", s_axis_tready, 1);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic recv(input logic [511:0] exp_tx, input int stall, input bit chk_dec,
                        output logic [511:0] got);
        int n;
        bit busy_bad = 0;
        got = '0;
        for (int b = 0; b < 8; b++) begin
            n = 0;
            @(negedge sys_clk);
            while (!m_axis_tvalid && n < 2000) begin
                if (s_axis_tready) busy_bad = 1;
                @(negedge sys_clk);
                n++;
            end
            if (!m_axis_tvalid) begin
                check("m_valid_timeout", m_axis_tvalid, 1);
                return;
            end
            if (b == stall) begin
                m_axis_tready = 1'b0;
                repeat (5) begin
                    check("stall_valid", m_axis_tvalid, 1);
                    check("stall_data", m_axis_tdata, exp_tx[511-64*b -: 64]);
                    check("stall_last", m_axis_tlast, (b == 7));
                    @(negedge sys_clk);
                end
                m_axis_tready = 1'b1;
            end
            if (s_axis_tready) busy_bad = 1;
            got[511-64*b -: 64] = m_axis_tdata;
            if (chk_dec || b >= 2) check($sformatf("beat%0d_data", b), m_axis_tdata, exp_tx[511-64*b -: 64]);
            check($sformatf("beat%0d_last", b), m_axis_tlast, (b == 7));
            @(posedge sys_clk);
            #1;
        end
        @(negedge sys_clk);
        check("tx_end_valid", m_axis_tvalid, 0);
        check("tx_end_s_ready", s_axis_tready, 1);
        check("s_ready_busy", busy_bad, 0);
    endtask

    task automatic run_txn(input logic [63:0] cfg, input logic [383:0] dframe,
                           input logic [127:0] eframe, input bit gap, input int stall,
                           input bit dec_known, input logic [127:0] dec_exp,
                           output logic [511:0] got);
        logic [383:0] enc_exp;
        logic [511:0] exp_tx;
        bit           chk_dec;
        enc_exp = enc_model(eframe, cfg);
`ifdef ENDEC_DECODER_EN
        exp_tx  = {dec_exp, enc_exp};
        chk_dec = dec_known;
`else
        exp_tx  = {dec_exp & 128'b0, enc_exp};
        chk_dec = dec_known | 1'b1;
`endif
        send_beat(cfg, gap);
        for (int k = 0; k < 6; k++) send_beat(dframe[383-64*k -: 64], gap);
        for (int k = 0; k < 2; k++) send_beat(eframe[127-64*k -: 64], gap);
        @(negedge sys_clk);
        s_axis_tvalid = 1'b0;
        recv(exp_tx, stall, chk_dec, got);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  cfg12, cfg13, cfgr;
        logic [127:0] f1, f2, f3, f4, onehot;
        logic [383:0] c12, cw;
        logic [511:0] got;

        cfg12  = {36'b0, 1'b0, 9'h000, 9'h005, 9'h007};
        cfg13  = {36'b0, 1'b1, 9'b100100111, 9'b110011011, 9'b111101101};
        onehot = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        c12    = '0;
        c12[255:250] = 6'b111011;

        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        #1;
        check("rst_s_ready", s_axis_tready, 0);
        check("rst_m_valid", m_axis_tvalid, 0);
        check("rst_m_last", m_axis_tlast, 0);
        check("rst_m_data", m_axis_tdata, 0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;

        // Rate 1/2 impulse response, decoder fed the same stream.
        run_txn(cfg12, c12, onehot, 0, -1, 1, onehot, got);
        check("imp_enc_hi", got[383:256], c12[383:256]);
        check("imp_enc_mid", got[255:128], c12[255:128]);
        check("imp_enc_lo", got[127:0], c12[127:0]);

        // Rate 1/3 round trip, then single flipped bit at 200 with a stalled output beat 3.
        f1 = rand128();
        f2 = rand128();
        run_txn(cfg13, enc_model(f1, cfg13), f2, 0, -1, 1, f1, got);
        cw = enc_model(f2, cfg13);
        cw[200] = ~cw[200];
        run_txn(cfg13, cw, f1, 0, 3, 1, f2, got);

        // Input valid toggling every other cycle.
        f3 = rand128();
        run_txn(cfg13, enc_model(f3, cfg13), f3, 1, -1, 1, f3, got);

        // Abort after data beat 4, then a clean transaction.
        send_beat(cfg13, 0);
        for (int k = 0; k < 5; k++) send_beat(64'(k) * 64'h0101_0101_0101_0101, 0);
        @(negedge sys_clk);
        s_axis_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_s_ready", s_axis_tready, 0);
        check("abort_m_valid", m_axis_tvalid, 0);
        check("abort_m_last", m_axis_tlast, 0);
        check("abort_m_data", m_axis_tdata, 0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        f4 = rand128();
        run_txn(cfg12, {128'b0, enc_model(f4, cfg12)[255:0]}, f4, 0, -1, 1, f4, got);

        // Rate 1/3 codewords with a random single-bit error.
        for (int t = 0; t < 2; t++) begin
            f1 = rand128();
            f2 = rand128();
            cw = enc_model(f1, cfg13);
            cw[$urandom_range(383, 0)] ^= 1'b1;
            run_txn(cfg13, cw, f2, 0, int'($urandom_range(7, 0)), 1, f1, got);
        end

        // Random polynomials and rate: encoder only, decoder output not predicted.
        for (int t = 0; t < 3; t++) begin
            cfgr = {$urandom, $urandom};
            f1   = rand128();
            run_txn(cfgr, {f1, rand128(), rand128()}, rand128(), t[0], -1, 0, 128'b0, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
